// File: rtl/fpaccum_pkg.sv
// Shared types and sizing helpers for the fixed-point window accumulator.
//   state_e   : accumulator FSM states (ACCUM collects products, DONE presents the sum)
//   acc_width : internal accumulator width for an n-bit input summed LEN times
//   cnt_width : product counter width (at least one bit, even for LEN=1)
package fpaccum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  function automatic int unsigned acc_width(input int unsigned n, input int unsigned len);
    return n + $clog2(len) + 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/fpaccum_sat.sv
// Clamps a wide accumulator value into the n-bit output range and flags clamping.
// Only instantiated when FPACCUM_SATURATE_EN is defined.
// Ports:
//   i_acc [W-1:0] : full-width window sum
//   o_msg [n-1:0] : clamped result (combinational)
//   o_sat         : 1 when o_msg differs from the true sum because of clamping
module fpaccum_sat
  import fpaccum_pkg::*;
#(
  parameter int unsigned W    = 35,
  parameter int unsigned n    = 32,
  parameter int unsigned sign = 1
) (
  input  logic [W-1:0] i_acc,
  output logic [n-1:0] o_msg,
  output logic         o_sat
);

  localparam int unsigned HW = W - n + 1;

  always_comb begin
    o_msg = i_acc[n-1:0];
    o_sat = 1'b0;
    if (sign != 0) begin
      // Signed fits only if every bit from n-1 upward copies the sign bit.
      if (i_acc[W-1:n-1] != {HW{i_acc[W-1]}}) begin
        o_sat = 1'b1;
        o_msg = i_acc[W-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
      end
    end else begin
      // Zero-extended sums never go negative; only the upper limit can be exceeded.
      if (|i_acc[W-1:n]) begin
        o_sat = 1'b1;
        o_msg = '1;
      end
    end
  end

endmodule

// File: rtl/fpaccum_window.sv
// Sums LEN consecutive fixed-point products from a val/rdy stream and emits one n-bit
// result per window on a second val/rdy port. Optional clamping via FPACCUM_SATURATE_EN;
// without it the result wraps (low n bits of the sum) and sat stays 0.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   recv_val/rdy/msg    : product input handshake and data (n bits)
//   send_val/rdy/msg    : window sum output handshake and data (n bits)
//   sat                 : send_msg was clamped (valid with send_val)
module fpaccum_window
  import fpaccum_pkg::*;
#(
  parameter int unsigned n    = 32,
  parameter int unsigned d    = 16,
  parameter int unsigned sign = 1,
  parameter int unsigned LEN  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] recv_msg,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] send_msg,
  output logic         sat
);

  localparam int unsigned W  = acc_width(n, LEN);
  localparam int unsigned CW = cnt_width(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  // Reject configurations the datapath cannot represent.
  if (LEN < 1 || LEN > 65536 || d > n) begin : g_param_err
    $error("fpaccum_window: illegal parameter combination");
  end

  state_e          r_state;
  logic [W-1:0]    r_acc;
  logic [CW-1:0]   r_count;
  logic            r_recv_rdy;
  logic            r_send_val;
  logic [n-1:0]    r_send_msg;
  logic            r_sat;

  logic [W-1:0]    w_ext;
  logic [W-1:0]    w_sum;
  logic [n-1:0]    w_msg;
  logic            w_sat;
  logic            w_recv_fire;

  // Widen the incoming product to the accumulator width.
  assign w_ext = (sign != 0) ? {{(W-n){recv_msg[n-1]}}, recv_msg}
                             : {{(W-n){1'b0}}, recv_msg};
  assign w_sum       = r_acc + w_ext;
  assign w_recv_fire = recv_val & r_recv_rdy;

`ifdef FPACCUM_SATURATE_EN
  fpaccum_sat #(
    .W    (W),
    .n    (n),
    .sign (sign)
  ) u_sat (
    .i_acc (w_sum),
    .o_msg (w_msg),
    .o_sat (w_sat)
  );
`else
  assign w_msg = w_sum[n-1:0];
  assign w_sat = 1'b0;
`endif

  // FSM, counter, accumulator and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ACCUM;
      r_acc      <= '0;
      r_count    <= '0;
      r_recv_rdy <= 1'b1;
      r_send_val <= 1'b0;
      r_send_msg <= '0;
      r_sat      <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_recv_fire) begin
            if (r_count == LAST) begin
              // Final product: capture result and restart the window in one edge.
              r_send_msg <= w_msg;
              r_sat      <= w_sat;
              r_acc      <= '0;
              r_count    <= '0;
              r_recv_rdy <= 1'b0;
              r_send_val <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_acc   <= w_sum;
              r_count <= r_count + CW'(1);
            end
          end
        end
        DONE: begin
          if (send_rdy) begin
            r_recv_rdy <= 1'b1;
            r_send_val <= 1'b0;
            r_state    <= ACCUM;
          end
        end
        default: begin
          r_recv_rdy <= 1'b1;
          r_send_val <= 1'b0;
          r_state    <= ACCUM;
        end
      endcase
    end
  end

  assign recv_rdy = r_recv_rdy;
  assign send_val = r_send_val;
  assign send_msg = r_send_msg;
  assign sat      = r_sat;

endmodule

// File: tb/tb_fpaccum_window.sv
// Randomized self-checking bench for fpaccum_window: one n=8,d=4,sign=1,LEN=4 instance and
// one n=8,sign=0,LEN=1 instance, both checked against an integer-arithmetic window model.
module tb_fpaccum_window;

  logic       clk = 1'b0;
  logic       reset;

  logic       recv_val, recv_rdy, send_val, send_rdy, sat;
  logic [7:0] recv_msg, send_msg;

  logic       u1_recv_val, u1_recv_rdy, u1_send_val, u1_send_rdy, u1_sat;
  logic [7:0] u1_recv_msg, u1_send_msg;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fpaccum_window #(.n(8), .d(4), .sign(1), .LEN(4)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .recv_msg (recv_msg),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .send_msg (send_msg),
    .sat      (sat)
  );

  fpaccum_window #(.n(8), .d(4), .sign(0), .LEN(1)) u_dut1 (
    .clk      (clk),
    .reset    (reset),
    .recv_val (u1_recv_val),
    .recv_rdy (u1_recv_rdy),
    .recv_msg (u1_recv_msg),
    .send_val (u1_send_val),
    .send_rdy (u1_send_rdy),
    .send_msg (u1_send_msg),
    .sat      (u1_sat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: true integer sum of the window, then clamp or wrap to 8 bits.
  function automatic void model(input int vals[$], input bit sgn,
                                output logic [7:0] msg, output logic s);
    int sum = 0;
    foreach (vals[i]) sum += (sgn && vals[i] >= 128) ? vals[i] - 256 : vals[i];
    s   = 1'b0;
    msg = 8'(sum);
`ifdef FPACCUM_SATURATE_EN
    if (sgn) begin
      if (sum > 127)       begin msg = 8'h7F; s = 1'b1; end
      else if (sum < -128) begin msg = 8'h80; s = 1'b1; end
    end else if (sum > 255) begin
      msg = 8'hFF; s = 1'b1;
    end
`endif
  endfunction

  // Present one product to the LEN=4 instance and return at the negedge after it is taken.
  task automatic put0(input logic [7:0] v);
    int k = 0;
    recv_msg = v;
    recv_val = 1'b1;
    while (!recv_rdy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("put_rdy", 32'(recv_rdy), 32'd1);
    @(negedge clk);
    recv_val = 1'b0;
  endtask

  // Feed one window, verify the result, hold it 'hold' cycles (offering a junk product),
  // then complete the output handshake.
  task automatic run_window(input int vals[$], input int hold, input bit gaps, input string tag);
    logic [7:0] em;
    logic       es;
    for (int i = 0; i < vals.size(); i++) begin
      if (gaps) begin
        recv_val = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      send_rdy = 1'($urandom_range(0, 1));
      if (i == vals.size() - 1) check({tag, "_pre_val"}, 32'(send_val), 32'd0);
      put0(8'(vals[i]));
    end
    send_rdy = 1'b0;
    model(vals, 1'b1, em, es);
    check({tag, "_val"}, 32'(send_val), 32'd1);
    check({tag, "_rdy_lo"}, 32'(recv_rdy), 32'd0);
    check({tag, "_msg"}, 32'(send_msg), 32'(em));
    check({tag, "_sat"}, 32'(sat), 32'(es));
    if (hold > 0) begin
      recv_val = 1'b1;
      recv_msg = 8'h7F;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_msg"}, 32'(send_msg), 32'(em));
      check({tag, "_hold_val"}, 32'(send_val), 32'd1);
      check({tag, "_hold_rdy"}, 32'(recv_rdy), 32'd0);
    end
    send_rdy = 1'b1;
    @(negedge clk);
    send_rdy = 1'b0;
    check({tag, "_post_val"}, 32'(send_val), 32'd0);
    check({tag, "_post_rdy"}, 32'(recv_rdy), 32'd1);
  endtask

  initial begin
    int q[$];
    logic [7:0] em;
    logic       es;

    reset       = 1'b1;
    recv_val    = 1'b0;
    recv_msg    = 8'h00;
    send_rdy    = 1'b0;
    u1_recv_val = 1'b0;
    u1_recv_msg = 8'h00;
    u1_send_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_recv_rdy", 32'(recv_rdy), 32'd1);
    check("rst_send_val", 32'(send_val), 32'd0);
    check("rst_send_msg", 32'(send_msg), 32'd0);
    check("rst_sat",      32'(sat),      32'd0);
    check("rst1_recv_rdy", 32'(u1_recv_rdy), 32'd1);
    check("rst1_send_val", 32'(u1_send_val), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Four 1.0 products back to back.
    q = {16, 16, 16, 16};
    run_window(q, 0, 1'b0, "ones");
    check("ones_const", 32'(send_msg), 32'h40);

    // Mixed signs cancelling to zero.
    q = {32, 240, 232, 8};
    run_window(q, 0, 1'b0, "mixed");

    // Positive and negative overflow.
    q = {112, 112, 112, 112};
    run_window(q, 0, 1'b0, "ovf_pos");
    q = {144, 144, 144, 144};
    run_window(q, 0, 1'b0, "ovf_neg");

    // Long stall in DONE with a product offered; it must not leak into the next window.
    q = {20, 4, 8, 200};
    run_window(q, 5, 1'b0, "stall");
    q = {1, 2, 3, 4};
    run_window(q, 0, 1'b0, "after_stall");
    check("after_stall_const", 32'(send_msg), 32'h0A);

    // Reset mid-window discards the partial sum.
    put0(8'h10);
    put0(8'h10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_val", 32'(send_val), 32'd0);
    check("midrst_rdy", 32'(recv_rdy), 32'd1);
    q = {8, 8, 8, 8};
    run_window(q, 0, 1'b0, "midrst");
    check("midrst_const", 32'(send_msg), 32'h20);

    // Random windows with input gaps and output back-pressure.
    for (int w = 0; w < 25; w++) begin
      q = {};
      for (int i = 0; i < 4; i++) q.push_back(int'($urandom_range(0, 255)));
      run_window(q, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand");
    end
    recv_val = 1'b0;

    // LEN=1 unsigned instance: each accepted product is its own window.
    for (int i = 0; i < 20; i++) begin
      int k = 0;
      logic [7:0] v;
      v = (i == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      u1_recv_val = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      u1_recv_msg = v;
      u1_recv_val = 1'b1;
      while (!u1_recv_rdy && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("l1_rdy", 32'(u1_recv_rdy), 32'd1);
      @(negedge clk);
      u1_recv_val = 1'b0;
      q = {int'(v)};
      model(q, 1'b0, em, es);
      check("l1_val", 32'(u1_send_val), 32'd1);
      check("l1_rdy_lo", 32'(u1_recv_rdy), 32'd0);
      check("l1_msg", 32'(u1_send_msg), 32'(em));
      check("l1_sat", 32'(u1_sat), 32'(es));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      u1_send_rdy = 1'b1;
      @(negedge clk);
      u1_send_rdy = 1'b0;
      check("l1_post_val", 32'(u1_send_val), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
